muldiv_unit: RTL

Parametrised multi-cycle multiply/divide unit for the Execute stage, the next generation of the fixed 32-bit HI/LO unit. It adds configurable data width and latencies, multiply-accumulate modes, defined divide-by-zero and overflow results, and a flush input that aborts an in-flight operation on exception or branch squash. It sits beside the ALU and takes forwarded RS/RT operands. It exposes `busy`/`start` to the hazard unit and HI/LO to the Memory-stage forwarding path.

---
 rtl/md_pkg.sv | 36 +++
 rtl/md_compute.sv | 65 ++++++
 rtl/muldiv_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, state encoding and default latencies for muldiv_unit
package md_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MADD  = 4'd3,
    OP_MADDU = 4'd4,
    OP_MSUB  = 4'd5,
    OP_MSUBU = 4'd6,
    OP_DIV   = 4'd7,
    OP_DIVU  = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// rtl/md_compute.sv - combinational {hi,lo} result for multiply, accumulate and divide ops
module md_compute
  import md_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      b_zero, div_ovf;
  logic [WIDTH-1:0]          divisor_u, quo_u, rem_u;
  logic signed [WIDTH-1:0]   a_s, divisor_s, quo_s, rem_s;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {ZERO, a} * {ZERO, b};

  assign b_zero  = (b == ZERO);
  assign div_ovf = (a == MIN) && (b == ONES);

  // Divisors are forced to 1 in the special cases so the dividers never see 0 or MIN/-1.
  assign divisor_u = b_zero ? ONE : b;
  assign quo_u     = a / divisor_u;
  assign rem_u     = a % divisor_u;

  assign a_s       = a;
  assign divisor_s = (b_zero || div_ovf) ? ONE : b;
  assign quo_s     = a_s / divisor_s;
  assign rem_s     = a_s % divisor_s;

  always_comb begin
    result = acc;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
      OP_DIV: begin
        if (b_zero)       result = {a, ONES};
        else if (div_ovf) result = {ZERO, MIN};
        else              result = {rem_s, quo_s};
      end
      OP_DIVU: begin
        if (b_zero) result = {a, ONES};
        else        result = {rem_u, quo_u};
      end
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO, accumulate modes and flush
module muldiv_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d, result;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               done_d;

  md_compute #(.WIDTH(WIDTH)) u_compute (
    .op     (op),
    .a      (a),
    .b      (b),
    .acc    ({hi, lo}),
    .result (result)
  );

  assign busy = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi;
    lo_d    = lo;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (is_mul_op(op) || is_div_op(op)) begin
            pend_d  = result;
            cnt_d   = is_div_op(op) ? DIV_LOAD : MUL_LOAD;
            state_d = ST_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        // Flush outranks the commit, even on the terminal edge.
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pend_d  = '0;
        end else if (cnt_q <= CNT_ONE) begin
          {hi_d, lo_d} = pend_q;
          state_d      = ST_IDLE;
          cnt_d        = '0;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi      <= hi_d;
      lo      <= lo_d;
      done    <= done_d;
    end
  end

endmodule
